// File: rtl/dmem_be_ctrl_pkg.sv
// Shared constants for the byte-enable data memory: read-during-write modes
// and controller state encoding.
package dmem_be_ctrl_pkg;

  localparam logic DMEM_RDW_OLD = 1'b0;
  localparam logic DMEM_RDW_NEW = 1'b1;

  typedef enum logic {
    DMEM_ST_CLEAR = 1'b0,
    DMEM_ST_RUN   = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_be_ram.sv
// Single-port DEPTH x DATA_LEN array with per-byte write enables and a
// read-first synchronous output register, shaped for byte-write BRAM inference.
module dmem_be_ram #(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 128,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = DATA_LEN / 8
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic [NB-1:0]       we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  output logic [DATA_LEN-1:0] rdata_o
);

  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [DATA_LEN-1:0] rdata_q;

  // Read-first port: the output register always sees the pre-write word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_be_ctrl.sv
// Data memory controller: post-reset clear sweep, valid/ready request port,
// range check, read-during-write merge and optional second response stage.
module dmem_be_ctrl
  import dmem_be_ctrl_pkg::*;
#(
  parameter int DATA_LEN       = 32,
  parameter int ADDR_LEN       = 32,
  parameter int DEPTH          = 128,
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_LEN-1:0]   req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  input  logic [DATA_LEN/8-1:0] req_be,
  output logic                  resp_valid,
  output logic [DATA_LEN-1:0]   resp_rdata,
  output logic                  resp_err
);

  localparam int   AW      = $clog2(DEPTH);
  localparam int   NB      = DATA_LEN / 8;
  localparam logic RDW_SEL = (RDW_MODE != 0) ? DMEM_RDW_NEW : DMEM_RDW_OLD;

  dmem_state_e   state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic                accept_s;
  logic                in_range_s;
  logic                ram_en_s;
  logic [NB-1:0]       ram_we_s;
  logic [AW-1:0]       ram_addr_s;
  logic [DATA_LEN-1:0] ram_wdata_s;
  logic [DATA_LEN-1:0] ram_rdata_s;

  logic                s1_valid_q, s1_err_q, s1_we_q;
  logic [NB-1:0]       s1_be_q;
  logic [DATA_LEN-1:0] s1_wdata_q;
  logic [DATA_LEN-1:0] merged_s, s1_rdata_s;

  assign req_ready  = (state_q == DMEM_ST_RUN);
  assign accept_s   = req_valid & req_ready & ~reset;
  assign in_range_s = ((req_addr >> AW) == {ADDR_LEN{1'b0}});

  // State and clear-counter register; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? DMEM_ST_CLEAR : DMEM_ST_RUN;
      clr_cnt_q <= {AW{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state: the sweep writes one word per cycle and leaves after DEPTH-1.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      DMEM_ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = DMEM_ST_RUN;
        end else begin
          state_d = DMEM_ST_CLEAR;
        end
      end
      DMEM_ST_RUN: begin
        state_d   = DMEM_ST_RUN;
        clr_cnt_d = {AW{1'b0}};
      end
      default: begin
        state_d   = DMEM_ST_CLEAR;
        clr_cnt_d = {AW{1'b0}};
      end
    endcase
  end

  // RAM port steering: sweep owns the port during CLEAR, requests in RUN.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = {NB{1'b0}};
    ram_addr_s  = req_addr[AW-1:0];
    ram_wdata_s = req_wdata;
    if (reset) begin
      ram_en_s = 1'b0;
    end else if (state_q == DMEM_ST_CLEAR) begin
      ram_en_s    = 1'b1;
      ram_we_s    = {NB{1'b1}};
      ram_addr_s  = clr_cnt_q;
      ram_wdata_s = {DATA_LEN{1'b0}};
    end else if (accept_s) begin
      ram_en_s = 1'b1;
      if (req_we && in_range_s) begin
        ram_we_s = req_be;
      end else begin
        ram_we_s = {NB{1'b0}};
      end
    end else begin
      ram_en_s = 1'b0;
    end
  end

  dmem_be_ram #(
    .DATA_LEN (DATA_LEN),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en_s),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // First response stage, aligned with the RAM output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_be_q    <= {NB{1'b0}};
      s1_wdata_q <= {DATA_LEN{1'b0}};
    end else begin
      s1_valid_q <= accept_s;
      s1_err_q   <= accept_s & ~in_range_s;
      s1_we_q    <= accept_s & req_we;
      if (accept_s) begin
        s1_be_q    <= req_be;
        s1_wdata_q <= req_wdata;
      end
    end
  end

  // Response data: zero unless valid and in range, merged word for new-data writes.
  always_comb begin
    merged_s = ram_rdata_s;
    for (int i = 0; i < NB; i++) begin
      if (s1_be_q[i]) begin
        merged_s[8*i +: 8] = s1_wdata_q[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = ram_rdata_s[8*i +: 8];
      end
    end
    if (!s1_valid_q || s1_err_q) begin
      s1_rdata_s = {DATA_LEN{1'b0}};
    end else if (s1_we_q && (RDW_SEL == DMEM_RDW_NEW)) begin
      s1_rdata_s = merged_s;
    end else begin
      s1_rdata_s = ram_rdata_s;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic                s2_valid_q, s2_err_q;
    logic [DATA_LEN-1:0] s2_rdata_q;

    // Extra response stage; reset discards anything in flight.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_rdata_q <= {DATA_LEN{1'b0}};
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        s2_rdata_q <= s1_rdata_s;
      end
    end

    assign resp_valid = s2_valid_q;
    assign resp_err   = s2_err_q;
    assign resp_rdata = s2_rdata_q;
  end else begin : g_lat1
    assign resp_valid = s1_valid_q;
    assign resp_err   = s1_err_q;
    assign resp_rdata = s1_rdata_s;
  end

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// Bench for dmem_be_ctrl: two instances (latency 1 / old-data and latency 2 /
// new-data) share one stimulus stream and are checked against a word-level model.
module tb_dmem_be_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        ready_a, valid_a, err_a;
  logic [31:0] rdata_a;
  logic        ready_b, valid_b, err_b;
  logic [31:0] rdata_b;

  always #5 clk = ~clk;

  dmem_be_ctrl #(
    .DATA_LEN(32), .ADDR_LEN(32), .DEPTH(128),
    .READ_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(valid_a), .resp_rdata(rdata_a), .resp_err(err_a)
  );

  dmem_be_ctrl #(
    .DATA_LEN(32), .ADDR_LEN(32), .DEPTH(128),
    .READ_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(valid_b), .resp_rdata(rdata_b), .resp_err(err_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clear_left = 128;

  // Model: memory contents plus, per clock edge, the response that edge's accept produces.
  logic [31:0] mem_m   [128];
  logic        rec_v   [4096];
  logic        rec_err [4096];
  logic [31:0] rec_old [4096];
  logic [31:0] rec_new [4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic        acc;
    logic [31:0] old_w, new_w;
    int          a;
    reset     = rst;
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    cyc++;
    rec_v[cyc]   = 1'b0;
    rec_err[cyc] = 1'b0;
    rec_old[cyc] = 32'h0;
    rec_new[cyc] = 32'h0;
    acc = !rst && v && (clear_left == 0);
    if (acc) begin
      rec_v[cyc] = 1'b1;
      if (addr >= 32'd128) begin
        rec_err[cyc] = 1'b1;
      end else begin
        a     = int'(addr);
        old_w = mem_m[a];
        new_w = old_w;
        for (int i = 0; i < 4; i++) begin
          if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
        end
        rec_old[cyc] = old_w;
        rec_new[cyc] = we ? new_w : old_w;
        if (we) mem_m[a] = new_w;
      end
    end
    if (rst) begin
      clear_left = 128;
      for (int i = 0; i < 128; i++) mem_m[i] = 32'h0;
    end else if (clear_left > 0) begin
      clear_left--;
    end
    #1;
    check("ready_a", {31'd0, ready_a}, {31'd0, clear_left == 0});
    check("ready_b", {31'd0, ready_b}, {31'd0, clear_left == 0});
    check("valid_a", {31'd0, valid_a}, {31'd0, rec_v[cyc]});
    check("err_a",   {31'd0, err_a},   {31'd0, rec_err[cyc]});
    check("rdata_a", rdata_a, rec_old[cyc]);
    check("valid_b", {31'd0, valid_b}, {31'd0, !rst && rec_v[cyc-1]});
    check("err_b",   {31'd0, err_b},   {31'd0, !rst && rec_err[cyc-1]});
    check("rdata_b", rdata_b, rst ? 32'h0 : rec_new[cyc-1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rec_v[i] = 1'b0; rec_err[i] = 1'b0; rec_old[i] = 32'h0; rec_new[i] = 32'h0;
    end
    for (int i = 0; i < 128; i++) mem_m[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;

    // Reset, then the 128-cycle clear sweep.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(127);
    check("clear_still_busy", {31'd0, ready_a}, 32'd0);
    idle(1);
    check("clear_done", {31'd0, ready_a}, 32'd1);

    step(1'b0, 1'b1, 1'b0, 32'd0,   32'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 32'd127, 32'h0, 4'h0);
    check("rd127_zero", rdata_a, 32'h0);
    idle(1);

    // Byte-lane merge.
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'hAABBCCDD, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'h11223344, 4'b0101);
    step(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
    check("rd5_a", rdata_a, 32'hAA22CC44);
    idle(1);
    check("rd5_b", rdata_b, 32'hAA22CC44);

    // Read-during-write data selection.
    step(1'b0, 1'b1, 1'b1, 32'd9, 32'h12345678, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 32'd9, 32'hFFFFFFFF, 4'b0011);
    check("rdw_old", rdata_a, 32'h12345678);
    idle(1);
    check("rdw_new", rdata_b, 32'h1234FFFF);
    step(1'b0, 1'b1, 1'b1, 32'd9, 32'h0, 4'b0000);
    idle(1);

    // Back-to-back reads through the two-stage pipe.
    step(1'b0, 1'b1, 1'b1, 32'd1, 32'h1, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 32'd2, 32'h2, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 32'd3, 32'h3, 4'b1111);
    step(1'b0, 1'b1, 1'b0, 32'd1, 32'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 32'd2, 32'h0, 4'h0);
    check("b2b_b1", rdata_b, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
    check("b2b_b2", rdata_b, 32'h2);
    idle(1);
    check("b2b_b3", rdata_b, 32'h3);

    // Out of range: no aliasing onto low words.
    step(1'b0, 1'b1, 1'b1, 32'd128, 32'hDEADBEEF, 4'b1111);
    check("oor_err", {31'd0, err_a}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 4'h0);
    check("oor_noalias", rdata_a, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0003, 32'hCAFEF00D, 4'b1111);
    step(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
    idle(1);

    // Reset in the middle of the sweep restarts it.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(60);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(128);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_0080) : 32'($urandom_range(0, 127));
      step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ra, $urandom, 4'($urandom));
    end

    // A read accepted just before reset never responds in the latency-2 pipe.
    step(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("reset_drop_b", {31'd0, valid_b}, 32'd0);
    idle(130);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 131)), $urandom, 4'($urandom));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
